alu: RTL and testbench
======================

# alu

Parameterised integer ALU for the RISC-V style datapath. It computes arithmetic, logic, shift, set-less-than and branch-compare results from two operands under a 4-bit `CONTROL` code. The result and a zero flag are registered once and feed the writeback and branch logic.

## Interface
- `size`, default 32: operand and result width in bits (≥ 8).
- `CLK`  in  1: system clock; all state updates on the rising edge.
- `RESET`  in  1: synchronous, active-high reset.
- `X`  in  size: operand A; rs1 or PC.
- `Y`  in  size: operand B; rs2 or immediate. Bits [4:0] are the shift amount.
- `CONTROL`  in  4: operation select.
- `RESULTADO`  out  size: registered operation result.
- `ZERO`  out  1: registered flag, high when the registered `RESULTADO` is all zeros.

## Operation
- Encoding of `CONTROL` to next `RESULTADO`:
  - `0000` ADD: X+Y, modulo 2^size, no overflow flag.
  - `0111` SUB: X−Y, modulo 2^size.
  - `0100` SLT: 1 if $signed(X) < $signed(Y), else 0.
  - `1100` SLTU: 1 if X < Y unsigned, else 0.
  - `0010` AND: X & Y.
  - `0001` OR: X | Y.
  - `1001` XOR: X ^ Y.
  - `1000` SLL: X << Y[4:0], zero fill.
  - `1010` SRL: X >> Y[4:0], zero fill.
  - `1110` SRA: X >>> Y[4:0], sign fill from X[size−1].
  - `1011` BGE: 1 if $signed(X) ≥ $signed(Y), else 0.
  - `1111` EQ: 1 if X == Y, else 0. The branch unit inverts this for BNE and uses it directly for BEQ.
- Compare results are zero-extended to `size` bits; only bit 0 can be 1.
- Shift amount is always Y[4:0]. Y[size−1:5] is ignored for shifts.
- Unused codes `0011`, `0101`, `0110`, `1101` (when not enabled, see Configuration) produce 0.
- Next `ZERO` = (next `RESULTADO` == 0). It is computed from the same combinational value, so it is always consistent with `RESULTADO`.
- No internal state other than the two output registers.

## Timing
- Single-cycle registered latency. Inputs sampled at rising edge N appear on `RESULTADO` and `ZERO` after edge N. They are stable for the whole following cycle.
- No handshake. A new operation is accepted every cycle. Inputs changing between edges have no effect until the next edge.
- `RESET` high at a rising edge forces `RESULTADO` = 0 and `ZERO` = 1, regardless of inputs.
- Operands are ignored while `RESET` is high.
- Reset mid-stream discards the in-flight result. The first post-reset result appears one edge after `RESET` is sampled low.
- Outputs hold their value until the next rising edge.
- Boundary behaviour:
  - ADD/SUB wrap silently (0xFFFFFFFF+1 = 0, `ZERO`=1).
  - SRA by 0 returns X.
  - SLT with X = 0x80000000, Y = 0x7FFFFFFF returns 1.

## Configuration
- `ALU_BGEU_EN`
  - Defined: code `1101` is BGEU, giving 1 if X ≥ Y unsigned, else 0.
  - Undefined: code `1101` produces 0 like the other unused codes.
  - All other encodings and timing are identical in both builds.

## Test plan
- Reset, then the arithmetic and logic codes, each checked one edge after apply:
  - Assert `RESET` for one edge → `RESULTADO`=0, `ZERO`=1.
  - `0000`, X=19, Y=2 → 21.
  - `0111`, X=22, Y=5 → 17.
  - `0010`, X=15, Y=9 → 9.
  - `0001`, X=15, Y=9 → 15.
  - `1001`, X=12, Y=5 → 9.
- Set-less-than, signed and unsigned:
  - `0100`, X=−5, Y=3 → 1.
  - `1100`, X=0xFFFFFFFF, Y=1 → 0, `ZERO`=1.
- Shifts:
  - `1000`, X=1, Y=2 → 4.
  - `1010`, X=4, Y=1 → 2.
  - `1110`, X=−8, Y=2 → −2 (0xFFFFFFFE).
- Branch compares:
  - `1011`, X=5, Y=3 → 1.
  - `1111`, X=4, Y=4 → 1.
  - `1111`, X=4, Y=5 → 0, `ZERO`=1.
- Wrap, unused code and configuration:
  - `0000`, X=0xFFFFFFFF, Y=1 → 0, `ZERO`=1.
  - Code `0011` → 0.
  - With `ALU_BGEU_EN` defined: `1101`, X=0xFFFFFFFF, Y=1 → 1.
- Synchronous reset:
  - Raise `RESET` during a stream of ADDs → outputs 0/1 after that edge.
  - Deassert → next ADD result appears one edge later.

Source files
------------

// File: rtl/alu.sv
// rtl/alu.sv - registered integer ALU with zero flag; optional BGEU code under ALU_BGEU_EN
module alu #(
    parameter int size = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [size-1:0] X,
    input  logic [size-1:0] Y,
    input  logic [3:0]      CONTROL,
    output logic [size-1:0] RESULTADO,
    output logic            ZERO
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b1100;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1110;
    localparam logic [3:0] OP_BGE  = 4'b1011;
    localparam logic [3:0] OP_EQ   = 4'b1111;
`ifdef ALU_BGEU_EN
    localparam logic [3:0] OP_BGEU = 4'b1101;
`endif

    logic [size-1:0] resultado_d, resultado_q;
    logic            zero_d, zero_q;
    logic [4:0]      shamt;

    assign shamt = Y[4:0];

    // Compare ops only ever set bit 0; the '0 default supplies the zero extension.
    always_comb begin
        resultado_d = '0;
        case (CONTROL)
            OP_ADD:  resultado_d = X + Y;
            OP_SUB:  resultado_d = X - Y;
            OP_SLT:  resultado_d[0] = ($signed(X) < $signed(Y));
            OP_SLTU: resultado_d[0] = (X < Y);
            OP_AND:  resultado_d = X & Y;
            OP_OR:   resultado_d = X | Y;
            OP_XOR:  resultado_d = X ^ Y;
            OP_SLL:  resultado_d = X << shamt;
            OP_SRL:  resultado_d = X >> shamt;
            OP_SRA:  resultado_d = $signed(X) >>> shamt;
            OP_BGE:  resultado_d[0] = ($signed(X) >= $signed(Y));
            OP_EQ:   resultado_d[0] = (X == Y);
`ifdef ALU_BGEU_EN
            OP_BGEU: resultado_d[0] = (X >= Y);
`endif
            default: resultado_d = '0;
        endcase
        zero_d = (resultado_d == '0);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            resultado_q <= '0;
            zero_q      <= 1'b1;
        end else begin
            resultado_q <= resultado_d;
            zero_q      <= zero_d;
        end
    end

    assign RESULTADO = resultado_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - scoreboard bench for alu with directed vectors
module tb_alu;

    logic        clk;
    logic        reset;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  control;
    logic [31:0] resultado;
    logic        zero;

    typedef struct {
        string       name;
        logic [31:0] exp_r;
        logic        exp_z;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    alu #(.size(32)) dut (
        .CLK(clk),
        .RESET(reset),
        .X(x),
        .Y(y),
        .CONTROL(control),
        .RESULTADO(resultado),
        .ZERO(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge; the expectation applies after the next rising edge.
    task automatic apply(input string name, input logic rst, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez);
        exp_t e;
        @(negedge clk);
        reset   = rst;
        control = op;
        x       = a;
        y       = b;
        e.name  = name;
        e.exp_r = er;
        e.exp_z = ez;
        exp_q.push_back(e);
    endtask

    // Monitor: one result per rising edge, matched in order against the queue.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (resultado !== e.exp_r) begin
                    failures++;
                    $display("FAIL %s RESULTADO actual=%h required=%h", e.name, resultado, e.exp_r);
                end
                checks++;
                if (zero !== e.exp_z) begin
                    failures++;
                    $display("FAIL %s ZERO actual=%b required=%b", e.name, zero, e.exp_z);
                end
            end
        end
    end

    initial begin
        logic bgeu_exp;
        int   waited;
`ifdef ALU_BGEU_EN
        bgeu_exp = 1'b1;
`else
        bgeu_exp = 1'b0;
`endif
        reset   = 1'b1;
        control = 4'b0000;
        x       = 32'd0;
        y       = 32'd0;

        apply("reset",      1'b1, 4'b0000, 32'd19,        32'd2,         32'd0,          1'b1);
        apply("add",        1'b0, 4'b0000, 32'd19,        32'd2,         32'd21,         1'b0);
        apply("sub",        1'b0, 4'b0111, 32'd22,        32'd5,         32'd17,         1'b0);
        apply("and",        1'b0, 4'b0010, 32'd15,        32'd9,         32'd9,          1'b0);
        apply("or",         1'b0, 4'b0001, 32'd15,        32'd9,         32'd15,         1'b0);
        apply("xor",        1'b0, 4'b1001, 32'd12,        32'd5,         32'd9,          1'b0);
        apply("slt_neg",    1'b0, 4'b0100, 32'hFFFFFFFB,  32'd3,         32'd1,          1'b0);
        apply("sltu_max",   1'b0, 4'b1100, 32'hFFFFFFFF,  32'd1,         32'd0,          1'b1);
        apply("sll",        1'b0, 4'b1000, 32'd1,         32'd2,         32'd4,          1'b0);
        apply("srl",        1'b0, 4'b1010, 32'd4,         32'd1,         32'd2,          1'b0);
        apply("sra_neg",    1'b0, 4'b1110, 32'hFFFFFFF8,  32'd2,         32'hFFFFFFFE,   1'b0);
        apply("bge_gt",     1'b0, 4'b1011, 32'd5,         32'd3,         32'd1,          1'b0);
        apply("eq_true",    1'b0, 4'b1111, 32'd4,         32'd4,         32'd1,          1'b0);
        apply("eq_false",   1'b0, 4'b1111, 32'd4,         32'd5,         32'd0,          1'b1);
        apply("add_wrap",   1'b0, 4'b0000, 32'hFFFFFFFF,  32'd1,         32'd0,          1'b1);
        apply("unused_0011",1'b0, 4'b0011, 32'd15,        32'd9,         32'd0,          1'b1);
        apply("unused_0101",1'b0, 4'b0101, 32'd15,        32'd9,         32'd0,          1'b1);
        apply("unused_0110",1'b0, 4'b0110, 32'd15,        32'd9,         32'd0,          1'b1);
        apply("code_1101",  1'b0, 4'b1101, 32'hFFFFFFFF,  32'd1,         {31'd0, bgeu_exp}, ~bgeu_exp);
        apply("sra_by0",    1'b0, 4'b1110, 32'h80000010,  32'h00000020,  32'h80000010,   1'b0);
        apply("sll_hi_ign", 1'b0, 4'b1000, 32'd3,         32'h00000021,  32'd6,          1'b0);
        apply("slt_bound",  1'b0, 4'b0100, 32'h80000000,  32'h7FFFFFFF,  32'd1,          1'b0);
        apply("sltu_bound", 1'b0, 4'b1100, 32'h80000000,  32'h7FFFFFFF,  32'd0,          1'b1);
        apply("bge_eq",     1'b0, 4'b1011, 32'd3,         32'd3,         32'd1,          1'b0);
        apply("bge_neg",    1'b0, 4'b1011, 32'hFFFFFFFF,  32'd0,         32'd0,          1'b1);
        apply("sub_wrap",   1'b0, 4'b0111, 32'd0,         32'd1,         32'hFFFFFFFF,   1'b0);
        apply("sra_pos",    1'b0, 4'b1110, 32'h7FFFFFF0,  32'd4,         32'h07FFFFFF,   1'b0);
        apply("srl_31",     1'b0, 4'b1010, 32'h80000000,  32'd31,        32'd1,          1'b0);
        apply("stream_add", 1'b0, 4'b0000, 32'd1,         32'd1,         32'd2,          1'b0);
        apply("mid_reset1", 1'b1, 4'b0000, 32'd7,         32'd7,         32'd0,          1'b1);
        apply("mid_reset2", 1'b1, 4'b0000, 32'd5,         32'd5,         32'd0,          1'b1);
        apply("post_reset", 1'b0, 4'b0000, 32'd3,         32'd4,         32'd7,          1'b0);
        apply("post_add2",  1'b0, 4'b0000, 32'd10,        32'd20,        32'd30,         1'b0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
